// File: rtl/lockstep_monitor_if.sv
// Bundle of lane inputs, test-inject mask, clear and monitor results for
// lockstep_monitor. The master drives lanes/inject/clear, the slave (monitor)
// drives the result fields.
interface lockstep_monitor_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned LANES = 2,
    parameter int unsigned CNT_W = 8
);
    logic [LANES*W-1:0] lane_in;
    logic [W-1:0]       inject;
    logic               clear;
    logic [W-1:0]       voted_out;
    logic               mismatch;
    logic [LANES-1:0]   err_lane;
    logic               DLS_ERROR;
    logic [CNT_W-1:0]   err_count;

    modport master (
        output lane_in, inject, clear,
        input  voted_out, mismatch, err_lane, DLS_ERROR, err_count
    );

    modport slave (
        input  lane_in, inject, clear,
        output voted_out, mismatch, err_lane, DLS_ERROR, err_count
    );
endinterface

// File: rtl/lockstep_monitor.sv
// Dual-lane lockstep comparator / triple-lane majority voter with a
// persistence filter, sticky DLS_ERROR and a saturating mismatch counter.
module lockstep_monitor #(
    parameter int unsigned W       = 32,
    parameter int unsigned LANES   = 2,
    parameter int unsigned PERSIST = 1,
    parameter int unsigned CNT_W   = 8
) (
    input logic               HCLK,
    input logic               HRESETn,
    lockstep_monitor_if.slave bus
);
    localparam int unsigned RUN_W = $clog2(PERSIST + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PERSIST);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (LANES != 2 && LANES != 3) begin : g_bad_lanes
        $error("lockstep_monitor: LANES must be 2 or 3");
    end
    if (W < 1 || W > 64) begin : g_bad_w
        $error("lockstep_monitor: W must be 1..64");
    end
    if (PERSIST < 1 || PERSIST > 255) begin : g_bad_persist
        $error("lockstep_monitor: PERSIST must be 1..255");
    end

    logic [W-1:0]     lane0;
    logic [W-1:0]     lane1;
    logic [W-1:0]     raw_voted;
    logic [LANES-1:0] raw_el;
    logic             raw_mm;

    // Lane 1 carries the fault-injection mask; other lanes are compared as-is.
    assign lane0 = bus.lane_in[0 +: W];
    assign lane1 = bus.lane_in[W +: W] ^ bus.inject;

    if (LANES == 3) begin : g_tmr
        logic [W-1:0] lane2;
        logic [W-1:0] maj;
        assign lane2     = bus.lane_in[2*W +: W];
        assign maj       = (lane0 & lane1) | (lane0 & lane2) | (lane1 & lane2);
        assign raw_voted = maj;
        assign raw_el    = {lane2 != maj, lane1 != maj, lane0 != maj};
    end else begin : g_dual
        assign raw_voted = lane0;
        assign raw_el    = {LANES{lane0 != lane1}};
    end

    assign raw_mm = |raw_el;

    logic [W-1:0]     voted_q;
    logic             mm_q;
    logic [LANES-1:0] el_q;
    logic [RUN_W-1:0] run_q, run_d;
    logic             dls_q, dls_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Per-cycle compare results, registered once; clear has no effect here.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            voted_q <= '0;
            mm_q    <= 1'b0;
            el_q    <= '0;
        end else begin
            voted_q <= raw_voted;
            mm_q    <= raw_mm;
            el_q    <= raw_el;
        end
    end

    // Persistence run, sticky error and event count; clear beats a same-cycle mismatch.
    always_comb begin
        run_d = run_q;
        dls_d = dls_q;
        cnt_d = cnt_q;
        if (bus.clear) begin
            run_d = '0;
            dls_d = 1'b0;
            cnt_d = '0;
        end else if (raw_mm) begin
            if (run_q != RUN_MAX) begin
                run_d = run_q + RUN_ONE;
            end
            if (run_d == RUN_MAX) begin
                dls_d = 1'b1;
            end
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            run_d = '0;
        end
    end

    // Error-tracking state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            run_q <= '0;
            dls_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            dls_q <= dls_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.voted_out = voted_q;
    assign bus.mismatch  = mm_q;
    assign bus.err_lane  = el_q;
    assign bus.DLS_ERROR = dls_q;
    assign bus.err_count = cnt_q;
endmodule
